// File: rtl/uart_tx_framed.sv
// UART transmitter with configurable width/parity/stop bits and a one-entry holding
// register so queued words go out back-to-back with no idle gap on the line.
module uart_tx_framed #(
  parameter int CLOCKS_PER_BIT = 4,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_tx,
  output logic                 out_busy,
  output logic                 out_done
);
  localparam int CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CYC_LAST  = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] CYC_DONE  = CW'(CLOCKS_PER_BIT - 2);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY == 1);

  generate
    if (PARITY < 0 || PARITY > 2 || CLOCKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
      $error("uart_tx_framed: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               state;
  logic [CW-1:0]        cyc_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [DATA_BITS-1:0] hold_reg;
  logic                 hold_full;
  logic                 accept;
  logic                 last_cyc;
  logic                 frame_end;

  assign in_ready  = !hold_full;
  assign out_busy  = (state != S_IDLE) || hold_full;
  assign accept    = in_valid && !hold_full;
  assign last_cyc  = (cyc_cnt == CYC_LAST);
  assign frame_end = (state == S_STOP) && last_cyc && (bit_cnt == STOP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cyc_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      out_tx    <= 1'b1;
      out_done  <= 1'b0;
    end else begin
      // done is raised one edge early so it is high during the final stop cycle
      out_done <= (state == S_STOP) && (bit_cnt == STOP_LAST) && (cyc_cnt == CYC_DONE);
      if (state == S_IDLE) begin
        if (accept) begin
          state   <= S_START;
          cyc_cnt <= '0;
          shreg   <= in_data;
          par_bit <= (^in_data) ^ PAR_ODD;
          out_tx  <= 1'b0;
        end
      end else begin
        if (accept && !frame_end) begin
          hold_reg  <= in_data;
          hold_full <= 1'b1;
        end
        if (!last_cyc) begin
          cyc_cnt <= cyc_cnt + 1'b1;
        end else begin
          cyc_cnt <= '0;
          unique case (state)
            S_START: begin
              state   <= S_DATA;
              bit_cnt <= '0;
              out_tx  <= shreg[0];
            end
            S_DATA: begin
              if (bit_cnt == DATA_LAST) begin
                bit_cnt <= '0;
                if (PARITY != 0) begin
                  state  <= S_PAR;
                  out_tx <= par_bit;
                end else begin
                  state  <= S_STOP;
                  out_tx <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= shreg >> 1;
                out_tx  <= shreg[1];
              end
            end
            S_PAR: begin
              state   <= S_STOP;
              bit_cnt <= '0;
              out_tx  <= 1'b1;
            end
            S_STOP: begin
              if (bit_cnt != STOP_LAST) begin
                bit_cnt <= bit_cnt + 1'b1;
              end else if (hold_full) begin
                // pending word follows with no idle cycle
                state     <= S_START;
                shreg     <= hold_reg;
                par_bit   <= (^hold_reg) ^ PAR_ODD;
                hold_full <= 1'b0;
                out_tx    <= 1'b0;
              end else if (accept) begin
                state   <= S_START;
                shreg   <= in_data;
                par_bit <= (^in_data) ^ PAR_ODD;
                out_tx  <= 1'b0;
              end else begin
                state  <= S_IDLE;
                out_tx <= 1'b1;
              end
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_framed.sv
// Bench for uart_tx_framed: four configurations (8N1, 8E1, 8O1, 7N2) checked
// against a bit-list frame model expanded to per-cycle line waveforms.
module tb_uart_tx_framed;
  localparam int CPB = 4;
  localparam int NI  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d0, d1, d2;
  logic [6:0] d3;
  logic       vin  [NI];
  logic       rdy  [NI];
  logic       tx   [NI];
  logic       busy [NI];
  logic       done [NI];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_framed #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .in_data(d0), .in_valid(vin[0]), .in_ready(rdy[0]),
    .out_tx(tx[0]), .out_busy(busy[0]), .out_done(done[0]));
  uart_tx_framed #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .in_data(d1), .in_valid(vin[1]), .in_ready(rdy[1]),
    .out_tx(tx[1]), .out_busy(busy[1]), .out_done(done[1]));
  uart_tx_framed #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .in_data(d2), .in_valid(vin[2]), .in_ready(rdy[2]),
    .out_tx(tx[2]), .out_busy(busy[2]), .out_done(done[2]));
  uart_tx_framed #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst(rst), .in_data(d3), .in_valid(vin[3]), .in_ready(rdy[3]),
    .out_tx(tx[3]), .out_busy(busy[3]), .out_done(done[3]));

  function automatic int db(input int k);
    return (k == 3) ? 7 : 8;
  endfunction
  function automatic int par(input int k);
    return (k == 1) ? 2 : (k == 2) ? 1 : 0;
  endfunction
  function automatic int sb(input int k);
    return (k == 3) ? 2 : 1;
  endfunction
  function automatic int flen(input int k);
    return (1 + db(k) + ((par(k) != 0) ? 1 : 0) + sb(k)) * CPB;
  endfunction
  function automatic logic [127:0] mask(input int n);
    return (n >= 128) ? '1 : ((128'd1 << n) - 128'd1);
  endfunction

  // Frame as a list of line levels, each stretched over CPB cycles at offset off.
  function automatic logic [127:0] wave(input int k, input logic [7:0] w, input int off,
                                        input logic [127:0] base);
    bit q[$];
    bit p;
    logic [127:0] r;
    r = base;
    p = 1'b0;
    q.push_back(1'b0);
    for (int i = 0; i < db(k); i++) begin
      q.push_back(w[i]);
      p = p ^ w[i];
    end
    if (par(k) == 2) q.push_back(p);
    else if (par(k) == 1) q.push_back(!p);
    for (int i = 0; i < sb(k); i++) q.push_back(1'b1);
    for (int i = 0; i < q.size() * CPB; i++) r[off + i] = q[i / CPB];
    return r;
  endfunction

  task automatic set_in(input int k, input logic v, input logic [7:0] w);
    vin[k] = v;
    case (k)
      0: d0 = w;
      1: d1 = w;
      2: d2 = w;
      default: d3 = w[6:0];
    endcase
  endtask

  task automatic kick(input int k, input logic [7:0] w);
    set_in(k, 1'b1, w);
    @(posedge clk);
    #1 set_in(k, 1'b0, 8'h00);
  endtask

  task automatic capture(input int k, input int n, output logic [127:0] tv,
                         output logic [127:0] dv, output logic [127:0] bv, output logic [127:0] rv);
    tv = '0; dv = '0; bv = '0; rv = '0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      tv[c] = tx[k]; dv[c] = done[k]; bv[c] = busy[k]; rv[c] = rdy[k];
    end
  endtask

  task automatic test_reset;
    for (int k = 0; k < NI; k++) set_in(k, 1'b0, 8'h00);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if ({tx[k], rdy[k], busy[k], done[k]} !== 4'b1100) begin
        failures++;
        $display("FAIL reset_in[%0d] got=%b want=1100", k, {tx[k], rdy[k], busy[k], done[k]});
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      checks++;
      if ({tx[k], rdy[k], busy[k], done[k]} !== 4'b1100) begin
        failures++;
        $display("FAIL reset_out[%0d] got=%b want=1100", k, {tx[k], rdy[k], busy[k], done[k]});
      end
    end
  endtask

  task automatic test_directed;
    logic [127:0] tv, dv, bv, rv, etx, m;
    logic [7:0] w;
    int n;
    for (int k = 0; k < NI; k++) begin
      w = (k == 0) ? 8'h55 : (k == 3) ? 8'h7F : 8'h07;
      n = flen(k) + 1;
      m = mask(n);
      etx = wave(k, w, 0, '1);
      kick(k, w);
      capture(k, n, tv, dv, bv, rv);
      checks++;
      if ((tv & m) !== (etx & m)) begin
        failures++;
        $display("FAIL directed_tx[%0d] got=%h want=%h", k, tv & m, etx & m);
      end
      checks++;
      if (dv !== (128'd1 << (flen(k) - 1))) begin
        failures++;
        $display("FAIL directed_done[%0d] got=%h want=%h", k, dv, 128'd1 << (flen(k) - 1));
      end
      checks++;
      if (bv !== mask(flen(k))) begin
        failures++;
        $display("FAIL directed_busy[%0d] got=%h want=%h", k, bv, mask(flen(k)));
      end
      if (k == 1 || k == 2) begin
        checks++;
        if (tv[36] !== (k == 1)) begin
          failures++;
          $display("FAIL parity_slot[%0d] got=%b want=%b", k, tv[36], (k == 1));
        end
      end
    end
  endtask

  task automatic test_random;
    logic [127:0] tv, dv, bv, rv, etx, m;
    logic [7:0] w;
    int k, n;
    for (int i = 0; i < 24; i++) begin
      k = $urandom_range(0, NI - 1);
      w = 8'($urandom) & (8'hFF >> (8 - db(k)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      n = flen(k) + 1;
      m = mask(n);
      etx = wave(k, w, 0, '1);
      kick(k, w);
      capture(k, n, tv, dv, bv, rv);
      checks++;
      if ((tv & m) !== (etx & m)) begin
        failures++;
        $display("FAIL random_tx[%0d] w=%h got=%h want=%h", k, w, tv & m, etx & m);
      end
      checks++;
      if (dv !== (128'd1 << (flen(k) - 1))) begin
        failures++;
        $display("FAIL random_done[%0d] got=%h want=%h", k, dv, 128'd1 << (flen(k) - 1));
      end
      checks++;
      if (bv !== mask(flen(k))) begin
        failures++;
        $display("FAIL random_busy[%0d] got=%h want=%h", k, bv, mask(flen(k)));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] tv, dv, bv, rv, etx, erd, m;
    m = mask(81);
    etx = wave(0, 8'h3C, 40, wave(0, 8'hA5, 0, '1));
    erd = ~(mask(40) ^ 128'd1);
    set_in(0, 1'b1, 8'hA5);
    fork
      begin
        @(posedge clk); #1 set_in(0, 1'b1, 8'h3C);
        @(posedge clk); #1 set_in(0, 1'b0, 8'h00);
      end
      begin
        @(posedge clk);
        capture(0, 81, tv, dv, bv, rv);
      end
    join
    checks++;
    if ((tv & m) !== (etx & m)) begin
      failures++;
      $display("FAIL b2b_tx got=%h want=%h", tv & m, etx & m);
    end
    checks++;
    if (dv !== ((128'd1 << 39) | (128'd1 << 79))) begin
      failures++;
      $display("FAIL b2b_done got=%h want=%h", dv, (128'd1 << 39) | (128'd1 << 79));
    end
    checks++;
    if (bv !== mask(80)) begin
      failures++;
      $display("FAIL b2b_busy got=%h want=%h", bv, mask(80));
    end
    checks++;
    if ((rv & m) !== (erd & m)) begin
      failures++;
      $display("FAIL b2b_ready got=%h want=%h", rv & m, erd & m);
    end
  endtask

  task automatic test_backpressure;
    logic [127:0] tv, dv, bv, rv, etx, erd, m;
    m = mask(126);
    etx = wave(0, 8'h11, 80, wave(0, 8'h33, 40, wave(0, 8'h22, 0, '1)));
    erd = ~((mask(40) ^ 128'd1) | (mask(80) ^ mask(41)));
    set_in(0, 1'b1, 8'h22);
    fork
      begin
        @(posedge clk); #1 set_in(0, 1'b1, 8'h33);
        @(posedge clk); #1 set_in(0, 1'b0, 8'h00);
        repeat (10) @(posedge clk);
        #1 set_in(0, 1'b1, 8'h11);
        repeat (30) @(posedge clk);
        #1 set_in(0, 1'b0, 8'h00);
      end
      begin
        @(posedge clk);
        capture(0, 126, tv, dv, bv, rv);
      end
    join
    checks++;
    if ((tv & m) !== (etx & m)) begin
      failures++;
      $display("FAIL bp_tx got=%h want=%h", tv & m, etx & m);
    end
    checks++;
    if (dv !== ((128'd1 << 39) | (128'd1 << 79) | (128'd1 << 119))) begin
      failures++;
      $display("FAIL bp_done got=%h want=%h", dv, (128'd1 << 39) | (128'd1 << 79) | (128'd1 << 119));
    end
    checks++;
    if (bv !== mask(120)) begin
      failures++;
      $display("FAIL bp_busy got=%h want=%h", bv, mask(120));
    end
    checks++;
    if ((rv & m) !== (erd & m)) begin
      failures++;
      $display("FAIL bp_ready got=%h want=%h", rv & m, erd & m);
    end
  endtask

  task automatic test_reset_mid;
    logic [127:0] tv, dv, bv, rv, etx, m;
    logic [7:0] w;
    set_in(0, 1'b1, 8'h00);
    @(posedge clk); #1 set_in(0, 1'b1, 8'h5A);
    @(posedge clk); #1 set_in(0, 1'b0, 8'h00);
    repeat (14) @(negedge clk);
    checks++;
    if ({tx[0], rdy[0], busy[0]} !== 3'b001) begin
      failures++;
      $display("FAIL midframe_pre got=%b want=001", {tx[0], rdy[0], busy[0]});
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({tx[0], rdy[0], busy[0], done[0]} !== 4'b1100) begin
      failures++;
      $display("FAIL midframe_async got=%b want=1100", {tx[0], rdy[0], busy[0], done[0]});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    capture(0, 20, tv, dv, bv, rv);
    checks++;
    if ({tv & mask(20), dv, bv} !== {mask(20), 128'd0, 128'd0}) begin
      failures++;
      $display("FAIL midframe_discard tx=%h done=%h busy=%h want tx=%h done=0 busy=0",
               tv & mask(20), dv, bv, mask(20));
    end
    w = 8'($urandom);
    m = mask(41);
    etx = wave(0, w, 0, '1);
    kick(0, w);
    capture(0, 41, tv, dv, bv, rv);
    checks++;
    if ((tv & m) !== (etx & m)) begin
      failures++;
      $display("FAIL after_reset_tx w=%h got=%h want=%h", w, tv & m, etx & m);
    end
    checks++;
    if (dv !== (128'd1 << 39)) begin
      failures++;
      $display("FAIL after_reset_done got=%h want=%h", dv, 128'd1 << 39);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
